// File: rtl/cnn_ctrl_pkg.sv
// Shared types for the CNN training sequencer: FSM states, stage codes and defaults.
package cnn_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_FETCH = 4'd1,
      ST_CONV  = 4'd2,
      ST_FC1   = 4'd3,
      ST_FC2   = 4'd4,
      ST_BP2   = 4'd5,
      ST_BP1   = 4'd6,
      ST_DONE  = 4'd7,
      ST_ERR   = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      STG_CONV = 3'd0,
      STG_FC1  = 3'd1,
      STG_FC2  = 3'd2,
      STG_BP2  = 3'd3,
      STG_BP1  = 3'd4
   } stage_e;

   localparam int DEFAULT_NUM_SAMPLES = 16;
   localparam int DEFAULT_NUM_EPOCHS  = 4;
   localparam int DEFAULT_TIMEOUT     = 15;

   function automatic stage_e stage_of(input state_t s);
      case (s)
         ST_CONV: stage_of = STG_CONV;
         ST_FC1:  stage_of = STG_FC1;
         ST_FC2:  stage_of = STG_FC2;
         ST_BP2:  stage_of = STG_BP2;
         ST_BP1:  stage_of = STG_BP1;
         default: stage_of = STG_CONV;
      endcase
   endfunction

   // BP1 is not listed: its exit depends on the sample/epoch counters.
   function automatic state_t next_stage(input state_t s);
      case (s)
         ST_CONV: next_stage = ST_FC1;
         ST_FC1:  next_stage = ST_FC2;
         ST_FC2:  next_stage = ST_BP2;
         ST_BP2:  next_stage = ST_BP1;
         default: next_stage = ST_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/cnn_train_sequencer_watchdog.sv
// Per-state cycle counter: restarts on every state change, qualifies done from the
// second cycle on and flags a stall once the count reaches TIMEOUT.
module stage_watchdog
   import cnn_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic qual_o,
   output logic timeout_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   // Saturate at TIMEOUT so a parked state never wraps back into the qualify window.
   always_comb begin
      timer_d = timer_q;
      if (clr_i) begin
         timer_d = {TW{1'b0}};
      end else if (timer_q != TW'(TIMEOUT)) begin
         timer_d = timer_q + TW'(1);
      end else begin
         timer_d = timer_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= {TW{1'b0}};
      end else begin
         timer_q <= timer_d;
      end
   end

   assign qual_o    = (timer_q != {TW{1'b0}});
   assign timeout_o = (timer_q == TW'(TIMEOUT));

endmodule

// File: rtl/cnn_train_sequencer.sv
// Training-step sequencer: fetch a sample, run conv/fc1/fc2/bp2/bp1 with one start
// pulse each, commit weights on bp1 done, and count samples and epochs.
module cnn_train_sequencer
   import cnn_ctrl_pkg::*;
#(
   parameter  int NUM_SAMPLES = DEFAULT_NUM_SAMPLES,
   parameter  int NUM_EPOCHS  = DEFAULT_NUM_EPOCHS,
   parameter  int TIMEOUT     = DEFAULT_TIMEOUT,
   localparam int SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
   localparam int EW = (NUM_EPOCHS > 1) ? $clog2(NUM_EPOCHS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          abort,
   input  logic          sample_valid,
   output logic          sample_ready,
   output logic [SW-1:0] sample_idx,
   output logic [EW-1:0] epoch_idx,
   output logic          conv_start,
   output logic          fc1_start,
   output logic          fc2_start,
   output logic          bp2_start,
   output logic          bp1_start,
   input  logic          conv_done,
   input  logic          fc1_done,
   input  logic          fc2_done,
   input  logic          bp2_done,
   input  logic          bp1_done,
   output logic          wb_en,
   output logic          busy,
   output logic          finished,
   output logic          error,
   output logic [2:0]    err_stage
);

   state_t        state_q, state_d;
   logic [SW-1:0] sample_q, sample_d;
   logic [EW-1:0] epoch_q, epoch_d;
   stage_e        err_stage_q, err_stage_d;
   logic [4:0]    start_q, start_d;

   logic qual_s, timeout_s, clr_s, done_s, fire_s;
   logic last_sample_s, last_epoch_s;

   stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr_s),
      .qual_o    (qual_s),
      .timeout_o (timeout_s)
   );

   // Only the done flag belonging to the current stage is visible to the FSM.
   always_comb begin
      case (state_q)
         ST_CONV: done_s = conv_done;
         ST_FC1:  done_s = fc1_done;
         ST_FC2:  done_s = fc2_done;
         ST_BP2:  done_s = bp2_done;
         ST_BP1:  done_s = bp1_done;
         default: done_s = 1'b0;
      endcase
   end

   assign fire_s        = qual_s && done_s;
   assign last_sample_s = (sample_q == SW'(NUM_SAMPLES - 1));
   assign last_epoch_s  = (epoch_q == EW'(NUM_EPOCHS - 1));
   assign clr_s         = (state_d != state_q);

   // Next-state and counter update; abort overrides every state.
   always_comb begin
      state_d     = state_q;
      sample_d    = sample_q;
      epoch_d     = epoch_q;
      err_stage_d = err_stage_q;
      if (abort) begin
         state_d     = ST_IDLE;
         sample_d    = {SW{1'b0}};
         epoch_d     = {EW{1'b0}};
         err_stage_d = STG_CONV;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run) begin
                  state_d  = ST_FETCH;
                  sample_d = {SW{1'b0}};
                  epoch_d  = {EW{1'b0}};
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (sample_valid) begin
                  state_d = ST_CONV;
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_CONV, ST_FC1, ST_FC2, ST_BP2: begin
               if (fire_s) begin
                  state_d = next_stage(state_q);
               end else if (timeout_s) begin
                  state_d     = ST_ERR;
                  err_stage_d = stage_of(state_q);
               end else begin
                  state_d = state_q;
               end
            end
            ST_BP1: begin
               if (fire_s) begin
                  if (last_sample_s) begin
                     sample_d = {SW{1'b0}};
                     // The final epoch index is kept so DONE reports the last epoch run.
                     if (last_epoch_s) begin
                        state_d = ST_DONE;
                     end else begin
                        epoch_d = epoch_q + EW'(1);
                        state_d = ST_FETCH;
                     end
                  end else begin
                     sample_d = sample_q + SW'(1);
                     state_d  = ST_FETCH;
                  end
               end else if (timeout_s) begin
                  state_d     = ST_ERR;
                  err_stage_d = STG_BP1;
               end else begin
                  state_d = ST_BP1;
               end
            end
            ST_DONE: begin
               if (!run) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Start pulse for the stage being entered; it lands in that stage's first cycle.
   always_comb begin
      start_d = 5'b00000;
      if (clr_s) begin
         case (state_d)
            ST_CONV: start_d = 5'b00001;
            ST_FC1:  start_d = 5'b00010;
            ST_FC2:  start_d = 5'b00100;
            ST_BP2:  start_d = 5'b01000;
            ST_BP1:  start_d = 5'b10000;
            default: start_d = 5'b00000;
         endcase
      end else begin
         start_d = 5'b00000;
      end
   end

   // State, counters, latched error stage and start pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sample_q    <= {SW{1'b0}};
         epoch_q     <= {EW{1'b0}};
         err_stage_q <= STG_CONV;
         start_q     <= 5'b00000;
      end else begin
         state_q     <= state_d;
         sample_q    <= sample_d;
         epoch_q     <= epoch_d;
         err_stage_q <= err_stage_d;
         start_q     <= start_d;
      end
   end

   assign conv_start   = start_q[0];
   assign fc1_start    = start_q[1];
   assign fc2_start    = start_q[2];
   assign bp2_start    = start_q[3];
   assign bp1_start    = start_q[4];
   assign sample_ready = (state_q == ST_FETCH);
   assign sample_idx   = sample_q;
   assign epoch_idx    = epoch_q;
   // Backprop results exist only in the bp1 done cycle, so the commit is not registered.
   assign wb_en        = (state_q == ST_BP1) && fire_s && !abort;
   assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
   assign finished     = (state_q == ST_DONE);
   assign error        = (state_q == ST_ERR);
   assign err_stage    = err_stage_q;

endmodule

// File: doc/cnn_train_sequencer.md
Name: cnn_train_sequencer

Overview:
- Control FSM that sequences one training step of the CNN datapath per sample: conv, fc1, fc2, fc2 backprop, then fc1 backprop.
- Fetches samples through a valid/ready handshake and issues one start pulse per stage, waiting on that stage's done.
- Produces the weight write-back strobe, counts samples and epochs, and traps stalled stages with a watchdog.
- Sits between the sample/weight memory front-end and the CNN datapath top.

Parameters:
- NUM_SAMPLES, 16, samples per epoch (>=1).
- NUM_EPOCHS, 4, epochs per run (>=1).
- TIMEOUT, 15, max cycles a stage may wait for done after its start cycle (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- run  in  1  level; rising activity starts a run from IDLE, low in DONE returns to IDLE.
- abort  in  1  synchronous abort from any state.
- sample_valid  in  1  sample source has the image and label ready.
- sample_ready  out  1  sequencer accepts a sample.
- sample_idx  out  $clog2(NUM_SAMPLES) (min 1)  index of the current sample.
- epoch_idx  out  $clog2(NUM_EPOCHS) (min 1)  current epoch.
- conv_start, fc1_start, fc2_start, bp2_start, bp1_start  out  1 each  one-cycle stage start pulses.
- conv_done, fc1_done, fc2_done, bp2_done, bp1_done  in  1 each  stage done flags.
- wb_en  out  1  commit updated fc1/fc2 weights and biases this cycle.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- finished  out  1  run complete.
- error  out  1  watchdog tripped.
- err_stage  out  3  stage that timed out (0 conv .. 4 bp1).

Behaviour:
- Reset: state IDLE. sample_idx=0, epoch_idx=0, timer=0. All outputs 0.
- States: IDLE, FETCH, CONV, FC1, FC2, BP2, BP1, DONE, ERR.
- IDLE: when run=1, clear counters and go to FETCH.
- FETCH: sample_ready=1 (combinational on state). On sample_valid=1 go to CONV.
- Stage states:
  - The start output is 1 only in the first cycle of the state (timer==0).
  - The timer increments each cycle in the state.
  - Done is honoured only when timer>=1; a done coincident with start is stale and ignored.
  - On done, go to the next stage: CONV->FC1->FC2->BP2->BP1.
  - If timer==TIMEOUT and no done: go to ERR, latch err_stage.
- BP1 exit:
  - wb_en = (state==BP1 && timer>=1 && bp1_done). It is combinational and coincident with done, because backprop outputs are valid only in that cycle.
  - In the same cycle: if sample_idx==NUM_SAMPLES-1, wrap sample_idx to 0 and increment epoch_idx; if epoch_idx==NUM_EPOCHS-1 as well, go to DONE. Otherwise go to FETCH with sample_idx+1.
- Latency: with sample_valid held high, one sample takes 11 cycles (1 FETCH + 5 stages × 2 cycles, with done the cycle after start). A run takes 11×NUM_SAMPLES×NUM_EPOCHS cycles plus 1 IDLE cycle.
- DONE: finished=1, counters hold. run=0 returns to IDLE; run held high stays in DONE (no auto-restart).
- ERR: error=1, err_stage held; all starts, wb_en and sample_ready are 0. Leaves only via abort or rst, both of which go to IDLE.
- Abort:
  - Highest priority after rst; the next state is IDLE with counters, error and err_stage cleared.
  - wb_en is forced 0 in an abort cycle, even if bp1_done is high.
- Done inputs outside their own stage state are ignored.
- Start outputs are registered (decoded from state and timer==0 via registered state), so they are glitch-free.

Decomposition:
- Package cnn_ctrl_pkg:
  - state_t enum.
  - stage_e enum with values 0..4, used for err_stage.
  - Localparam for the default TIMEOUT.
- Sub-module stage_watchdog: cycle counter with clear-on-state-entry, a done-qualify output (timer>=1) and a timeout flag.

Test Plan:
- Single sample (NUM_SAMPLES=1, NUM_EPOCHS=1), valid always high, each done one cycle after its start -> starts at cycles 2,4,6,8,10 after run; wb_en coincident with bp1_done; finished=1 at cycle 12; exactly one wb_en.
- NUM_SAMPLES=3, NUM_EPOCHS=2 -> 6 wb_en pulses; sample_idx sequence 0,1,2,0,1,2; epoch_idx goes 0->1 after the third pulse; finished after 67 cycles.
- sample_valid delayed 5 cycles in FETCH -> sample_ready held 5 cycles; conv_start one cycle after the handshake; no start asserted early.
- fc2_done never asserted, TIMEOUT=15 -> ERR entered 15 cycles after fc2_start; error=1, err_stage=2; no further starts or wb_en; abort returns to IDLE with error=0.
- abort asserted in the same cycle as bp1_done -> wb_en=0, next state IDLE, counters 0.
- conv_done held high continuously (stale) -> CONV still lasts 2 cycles; fc1_done pulsed during CONV is ignored and FC1 waits for a fresh done.
